// File: rtl/tt_sweep_engine.sv
// Exhaustive truth-table sweeper: steps stim through every input combination,
// waits SETTLE cycles per vector, then folds resp into a signature and a minterm count.
module tt_sweep_engine #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned SIG_W  = 16,
  parameter logic [15:0] POLY   = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] resp,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic [N_IN:0]    ones
);

  localparam int unsigned     CntW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [SIG_W-1:0] PolyW  = SIG_W'(POLY);

  typedef enum logic [1:0] {StIdle, StWait, StCapture, StFinish} state_e;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [N_IN:0]    ones_q, ones_d;
  logic [SIG_W-1:0] sig_step;

  assign sig_step = (sig_q << 1) ^ (sig_q[SIG_W-1] ? PolyW : '0) ^ SIG_W'(resp);

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sig_d   = sig_q;
    ones_d  = ones_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          stim_d  = '0;
          sig_d   = '0;
          ones_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (abort) begin
          stim_d  = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCapture: begin
        // An abort here discards the pending sample; partial results stay visible.
        if (abort) begin
          stim_d  = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          sig_d  = sig_step;
          ones_d = ones_q + {{N_IN{1'b0}}, resp[0]};
          if (stim_q == '1) begin
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StFinish;
          end else begin
            stim_d  = stim_q + 1'b1;
            cnt_d   = '0;
            state_d = StWait;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stim_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sig_q   <= sig_d;
      ones_q  <= ones_d;
    end
  end

  assign stim = stim_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sig  = sig_q;
  assign ones = ones_q;

endmodule

// File: tb/tb_tt_sweep_engine.sv
// Self-checking bench for tt_sweep_engine: two instances (N_IN=3/SETTLE=1 and
// N_IN=2/SETTLE=3 with a 2-cycle-delayed unit under test) against a signature model.
module tb_tt_sweep_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [1:0]  resp_a;
  logic [2:0]  stim_a;
  logic        busy_a, done_a;
  logic [15:0] sig_a;
  logic [3:0]  ones_a;

  logic        start_b = 1'b0, abort_b = 1'b0;
  logic        resp_b;
  logic [1:0]  stim_b;
  logic        busy_b, done_b;
  logic [7:0]  sig_b;
  logic [2:0]  ones_b;

  logic [1:0]  tt_a [8];
  logic        tt_b [4];
  logic        d1 = 1'b0, d2 = 1'b0;
  logic [15:0] exp_sig_a;
  logic [3:0]  exp_ones_a;
  int          errors = 0;
  int          checks = 0;

  tt_sweep_engine #(.N_IN(3), .N_OUT(2), .SETTLE(1), .SIG_W(16), .POLY(16'h1021)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .resp(resp_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .sig(sig_a), .ones(ones_a)
  );

  tt_sweep_engine #(.N_IN(2), .N_OUT(1), .SETTLE(3), .SIG_W(8), .POLY(16'h001D)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .resp(resp_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .sig(sig_b), .ones(ones_b)
  );

  always #5 clk = ~clk;

  // Unit under test for instance A is purely combinational; B's answer lags stim by 2 cycles.
  assign resp_a = tt_a[stim_a];
  assign resp_b = d2;
  always @(posedge clk) begin
    d1 <= tt_b[stim_b];
    d2 <= d1;
  end

  function automatic logic [15:0] model_sig(input int w, input logic [15:0] poly,
                                            input logic [15:0] rv [16], input int n);
    int unsigned s = 0;
    int unsigned mask = (32'd1 << w) - 32'd1;
    for (int i = 0; i < n; i++) begin
      s = ((s << 1) ^ ((((s >> (w - 1)) & 32'd1) != 0) ? 32'(poly) : 32'd0) ^ 32'(rv[i])) & mask;
    end
    return 16'(s);
  endfunction

  function automatic int model_ones(input logic [15:0] rv [16], input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(rv[i][0]);
    return c;
  endfunction

  // Caller is at a negedge; start is applied immediately so back-to-back runs are possible.
  task automatic run_a(input bit poke, input int abort_at, input bit abort_fin);
    logic [15:0] rv [16];
    int          total = 16;
    int          last;
    int          n;
    logic [2:0]  es;
    logic        eb, ed;
    for (int i = 0; i < 16; i++) rv[i] = 16'd0;
    for (int i = 0; i < 8; i++) rv[i] = 16'(tt_a[i]);
    last = (abort_at >= 0) ? abort_at + 1 : total;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(negedge clk);
      if (abort_at >= 0 && k == last) begin
        es = 3'd0; eb = 1'b0; ed = 1'b0;
      end else begin
        es = (k < total) ? 3'(k / 2) : 3'd0;
        eb = (k < total);
        ed = (k == total);
      end
      checks++;
      if (stim_a !== es) begin
        errors++; $display("FAIL a_stim k=%0d got %0d want %0d", k, stim_a, es);
      end
      checks++;
      if (busy_a !== eb) begin
        errors++; $display("FAIL a_busy k=%0d got %0b want %0b", k, busy_a, eb);
      end
      checks++;
      if (done_a !== ed) begin
        errors++; $display("FAIL a_done k=%0d got %0b want %0b", k, done_a, ed);
      end
      start_a = (poke && k < total - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort_a = (k == abort_at) || (abort_fin && k == total);
    end
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++; $display("FAIL a_idle got busy=%0b done=%0b want 0 0", busy_a, done_a);
    end
    n = (abort_at >= 0) ? abort_at / 2 : 8;
    exp_sig_a  = model_sig(16, 16'h1021, rv, n);
    exp_ones_a = 4'(model_ones(rv, n));
    checks++;
    if (sig_a !== exp_sig_a) begin
      errors++; $display("FAIL a_sig n=%0d got %h want %h", n, sig_a, exp_sig_a);
    end
    checks++;
    if (ones_a !== exp_ones_a) begin
      errors++; $display("FAIL a_ones n=%0d got %0d want %0d", n, ones_a, exp_ones_a);
    end
    if (abort_at >= 0) begin
      int pulses = 0;
      repeat (20) begin
        @(negedge clk);
        if (done_a) pulses++;
      end
      checks++;
      if (pulses != 0) begin
        errors++; $display("FAIL a_abort_nodone got %0d pulses want 0", pulses);
      end
    end
  endtask

  task automatic run_b();
    logic [15:0] rv [16];
    logic [7:0]  esig;
    logic [2:0]  eones;
    logic [1:0]  es;
    for (int i = 0; i < 16; i++) rv[i] = 16'd0;
    for (int i = 0; i < 4; i++) rv[i] = 16'(tt_b[i]);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      es = (k < 16) ? 2'(k / 4) : 2'd0;
      checks++;
      if (stim_b !== es || busy_b !== (k < 16) || done_b !== (k == 16)) begin
        errors++;
        $display("FAIL b_step k=%0d got stim=%0d busy=%0b done=%0b want %0d %0b %0b",
                 k, stim_b, busy_b, done_b, es, (k < 16), (k == 16));
      end
    end
    @(negedge clk);
    esig  = 8'(model_sig(8, 16'h001D, rv, 4));
    eones = 3'(model_ones(rv, 4));
    checks++;
    if (sig_b !== esig) begin
      errors++; $display("FAIL b_sig got %h want %h", sig_b, esig);
    end
    checks++;
    if (ones_b !== eones) begin
      errors++; $display("FAIL b_ones got %0d want %0d", ones_b, eones);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) tt_a[i] = 2'd0;
    for (int i = 0; i < 4; i++) tt_b[i] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stim_a, busy_a, done_a, sig_a, ones_a} !== '0) begin
      errors++; $display("FAIL reset_a got stim=%0d busy=%0b done=%0b sig=%h ones=%0d want 0",
                         stim_a, busy_a, done_a, sig_a, ones_a);
    end
    checks++;
    if ({stim_b, busy_b, done_b, sig_b, ones_b} !== '0) begin
      errors++; $display("FAIL reset_b got stim=%0d busy=%0b done=%0b sig=%h ones=%0d want 0",
                         stim_b, busy_b, done_b, sig_b, ones_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_parity();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      tt_a[i] = {1'($urandom), ^v};
    end
    run_a(1'b0, -1, 1'b0);
    checks++;
    if (ones_a !== 4'd4) begin
      errors++; $display("FAIL parity_ones got %0d want 4", ones_a);
    end
  endtask

  task automatic test_const();
    for (int i = 0; i < 8; i++) tt_a[i] = 2'd0;
    run_a(1'b0, -1, 1'b0);
    checks++;
    if (sig_a !== 16'h0000) begin
      errors++; $display("FAIL const0_sig got %h want 0000", sig_a);
    end
    for (int i = 0; i < 8; i++) tt_a[i] = 2'd1;
    run_a(1'b0, -1, 1'b0);
    checks++;
    if (ones_a !== 4'd8) begin
      errors++; $display("FAIL const1_ones got %0d want 8", ones_a);
    end
  endtask

  // Consecutive runs start in the idle cycle right after done; mid-sweep starts are poked.
  task automatic test_back_to_back();
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 8; i++) tt_a[i] = 2'($urandom);
      run_a(1'b1, -1, it == 2);
    end
  endtask

  task automatic test_settle();
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 4; i++) tt_b[i] = 1'($urandom);
      run_b();
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) tt_a[i] = 2'($urandom);
    run_a(1'b0, 10, 1'b0);
    run_a(1'b0, -1, 1'b0);
    run_a(1'b0, 2 * int'($urandom_range(0, 7)) + 1, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    start_a = 1'b1;
    abort_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || stim_a !== 3'd0) begin
        errors++; $display("FAIL start_abort got busy=%0b stim=%0d want 0 0", busy_a, stim_a);
      end
    end
    start_a = 1'b0;
    abort_a = 1'b0;
    checks++;
    if (sig_a !== exp_sig_a || ones_a !== exp_ones_a) begin
      errors++; $display("FAIL start_abort_hold got sig=%h ones=%0d want %h %0d",
                         sig_a, ones_a, exp_sig_a, exp_ones_a);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) tt_a[i] = 2'($urandom);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stim_a, busy_a, done_a, sig_a, ones_a} !== '0) begin
      errors++; $display("FAIL async_reset got stim=%0d busy=%0b done=%0b sig=%h ones=%0d want 0",
                         stim_a, busy_a, done_a, sig_a, ones_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_a(1'b0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_parity();
    test_const();
    test_back_to_back();
    test_settle();
    test_abort();
    test_start_abort_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_sweep_engine.md
# tt_sweep_engine

Parametrised exhaustive truth-table sweeper for combinational units under test. On `start` it drives every input combination 0 … 2^N_IN−1 onto `stim`, holds each for a programmable settle time, samples `resp`, and compacts responses into a signature register and a minterm count. It replaces hand-written per-vector stimulus sequences with a clocked, self-timed sweep that any bench or on-chip self-test wrapper can instantiate around a combinational block.

## Interface
- `N_IN`, 3, number of DUT inputs driven (1–16)
- `N_OUT`, 1, number of DUT outputs sampled (1 ≤ N_OUT ≤ SIG_W)
- `SETTLE`, 1, cycles each vector is held before sampling (≥1)
- `SIG_W`, 16, signature register width
- `POLY`, 16'h1021, signature feedback polynomial (low SIG_W bits used)

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin sweep; sampled only in IDLE
- `abort`  in  1  cancel sweep in progress
- `resp`  in  N_OUT  DUT outputs
- `stim`  out  N_IN  DUT inputs, registered
- `busy`  out  1  high from the cycle after `start` until the sweep ends
- `done`  out  1  one-cycle pulse on sweep completion
- `sig`  out  SIG_W  response signature
- `ones`  out  N_IN+1  count of vectors with `resp[0]`==1

## Operation
- Reset (async, `rst_n`=0): state IDLE; `stim`=0, `busy`=0, `done`=0, `sig`=0, `ones`=0.
- States: IDLE, WAIT, CAPTURE, FINISH.
- IDLE: `start`=1 and `abort`=0 → `stim`←0, `sig`←0, `ones`←0, settle counter←0, `busy`←1, go to WAIT. `sig`/`ones` otherwise hold previous results.
- WAIT: settle counter increments. When counter==SETTLE−1, go to CAPTURE. `stim` is held constant.
- CAPTURE: `sig`←((`sig`<<1) ^ (`sig`[SIG_W−1] ? POLY : 0)) ^ zero-extended `resp`; `ones`←`ones`+`resp`[0].
  - If `stim` is all ones → FINISH, `stim`←0, `busy`←0.
  - Else `stim`←`stim`+1, counter←0, go to WAIT.
- FINISH: `done`=1 for exactly this one cycle, then IDLE. `sig`/`ones` hold the final values until the next accepted `start`.
- `start` while not in IDLE: ignored, with no restart.
- `abort` in WAIT or CAPTURE: next edge → IDLE, `stim`←0, `busy`←0, no `done`. `sig`/`ones` keep their partial values, and the CAPTURE update is suppressed on that edge.
- `abort` in FINISH: ignored, so `done` still pulses. `abort`+`start` together in IDLE: `abort` wins and the block stays idle.
- `ones` cannot overflow: the maximum is 2^N_IN, which fits N_IN+1 bits.

## Timing
- All outputs are registered; there is no combinational path from `resp`/`start` to any output.
- Each vector occupies SETTLE+1 cycles: SETTLE in WAIT, 1 in CAPTURE. `resp` is sampled on the edge ending CAPTURE, which is SETTLE+1 edges after `stim` changed.
- `busy` rises on the edge sampling `start`. `done` is high during the cycle following edge 2^N_IN·(SETTLE+1) counted from the start edge.
- Example: N_IN=3, SETTLE=1 gives 16 cycles from `start` to `done`.
- Back-to-back sweeps: `start` may be asserted in the cycle after `done`, once the block is in IDLE.
- Reset mid-sweep takes effect immediately, independent of `clk`. The first accepted `start` is on the first rising edge after `rst_n` deasserts.

## Test plan
- N_IN=3, SETTLE=1, `resp`=parity(`stim`). Pulse `start`. Required: `stim` steps 0..7, each held 2 cycles; `done` pulses 16 cycles after start; `ones`=4; `sig` equals the bench model; `busy` falls with entry to FINISH.
- N_IN=3, `resp`=0 constant → `sig`=0, `ones`=0. Repeat with `resp`=1 → `ones`=8, `sig` equals the bench model.
- SETTLE=3, N_IN=2 → each vector held 3 cycles before sampling; `done` at 16 cycles. Delay the DUT model by 2 cycles and check that the signature still matches the undelayed expectation.
- `abort` during vector 5 of an N_IN=3 sweep → IDLE next edge, `stim`=0, `busy`=0, no `done`, `ones` equals the count of vectors 0–4. A following `start` gives a clean full-sweep result.
- Pulse `start` repeatedly mid-sweep → no restart, identical final `sig`/`ones`. `start`+`abort` together in IDLE → `busy` stays 0.
- Drop `rst_n` asynchronously between clock edges mid-sweep → all outputs go to zero immediately; after release, a full sweep completes normally.
